// File: rtl/prefetch_page_cache.sv
// prefetch_page_cache: direct-mapped instruction page cache, filled line by line, with next-page lookahead.
// Latency: a hit returns FDATA/FERR with FRDY one cycle after FREQ; a miss raises ACT the following cycle.
// Backpressure: line requests hold while NEXT=0; a missing requester holds FREQ/FADDR until FRDY.
// Ports: CLK/RESET (sync, active-high); fetch side FREQ/FADDR in, FRDY/FDATA/FERR out; FLUSH drops all pages;
//        fill bus ACT/OFFSET/TAGo out with NEXT in, returned lines DRDY/DERR/DTi in (request order);
//        status BUSY (fill in progress), FATAL (sticky fill timeout).
module prefetch_page_cache #(
  parameter int AW        = 34,
  parameter int PAGE_BITS = 8,
  parameter int LINE_BITS = 4,
  parameter int LOOKAHEAD = 1,
  parameter int TMO_BITS  = 8
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            FREQ,
  input  logic [AW-1:0]   FADDR,
  output logic            FRDY,
  output logic [63:0]     FDATA,
  output logic            FERR,
  input  logic            FLUSH,
  output logic            ACT,
  input  logic            NEXT,
  output logic [AW+2:0]   OFFSET,
  output logic [2:0]      TAGo,
  input  logic            DRDY,
  input  logic            DERR,
  input  logic [63:0]     DTi,
  output logic            BUSY,
  output logic            FATAL
);

  localparam int TAG_W = AW - PAGE_BITS - LINE_BITS;
  localparam int PG_W  = AW - LINE_BITS;
  localparam int SLOTS = 1 << PAGE_BITS;
  localparam int WORDS = 1 << (PAGE_BITS + LINE_BITS);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  state_t state, state_nxt;

  // storage: {err, data} per word, one tag per page slot, valid per slot
  logic [64:0]      data_ram [WORDS];
  logic [TAG_W-1:0] tag_ram  [SLOTS];
  logic [SLOTS-1:0] valid;

  // fill context
  logic [PG_W-1:0]      page;
  logic                 pf_fill;
  logic                 discard;
  logic [LINE_BITS-1:0] load_cntr;
  logic [LINE_BITS-1:0] data_cntr;
  logic [TMO_BITS-1:0]  tmo_cntr;
  logic [TMO_BITS-1:0]  tmo_sat;
  logic                 fatal_q;

  // fetch response registers
  logic        frdy_q;
  logic [63:0] fdata_q;
  logic        ferr_q;

  // lookup
  logic [PG_W-1:0]      f_page;
  logic [TAG_W-1:0]     f_tag;
  logic [PAGE_BITS-1:0] f_idx;
  logic [LINE_BITS-1:0] f_line;
  logic [PAGE_BITS-1:0] page_idx;
  logic                 tag_hit, fill_hit, hit;

  // lookahead candidate
  logic [PG_W-1:0]      pf_page;
  logic [PAGE_BITS-1:0] pf_idx;
  logic [TAG_W-1:0]     pf_tag;
  logic                 pf_present;

  // FSM controls
  logic act, start_fill, start_pf, fill_done, line_wr, last_load, last_data;

  assign f_page   = FADDR[AW-1:LINE_BITS];
  assign f_tag    = FADDR[AW-1 -: TAG_W];
  assign f_idx    = FADDR[LINE_BITS +: PAGE_BITS];
  assign f_line   = FADDR[LINE_BITS-1:0];
  assign page_idx = page[PAGE_BITS-1:0];

  assign tag_hit  = valid[f_idx] && (tag_ram[f_idx] == f_tag);
  // hit-under-fill: only lines already written into the page being loaded
  assign fill_hit = (state != S_IDLE) && !discard && (f_page == page) && (f_line < data_cntr);
  assign hit      = tag_hit || fill_hit;

  // page+1 wraps naturally at the top of the address space
  assign pf_page    = page + PG_W'(1);
  assign pf_idx     = pf_page[PAGE_BITS-1:0];
  assign pf_tag     = pf_page[PG_W-1:PAGE_BITS];
  assign pf_present = valid[pf_idx] && (tag_ram[pf_idx] == pf_tag);

  assign last_load = &load_cntr;
  assign last_data = &data_cntr;
  assign line_wr   = (state == S_WAIT) && DRDY;
  assign tmo_sat   = (&tmo_cntr) ? tmo_cntr : tmo_cntr + TMO_BITS'(1);

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    act        = 1'b0;
    start_fill = 1'b0;
    start_pf   = 1'b0;
    fill_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (FREQ && !hit) begin
          start_fill = 1'b1;
          state_nxt  = S_REQ;
        end
      end
      S_REQ: begin
        act = 1'b1;
        if (NEXT && last_load) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (DRDY && last_data) begin
          fill_done = 1'b1;
          // lookahead only follows a completed, kept demand fill; a flush cancels it
          if ((LOOKAHEAD != 0) && !pf_fill && !discard && !FLUSH && !pf_present) begin
            start_pf  = 1'b1;
            state_nxt = S_REQ;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid     <= '0;
      page      <= '0;
      pf_fill   <= 1'b0;
      discard   <= 1'b0;
      load_cntr <= '0;
      data_cntr <= '0;
      tmo_cntr  <= '0;
      fatal_q   <= 1'b0;
      frdy_q    <= 1'b0;
    end else begin
      frdy_q <= FREQ && hit;

      if (act && NEXT) load_cntr <= load_cntr + LINE_BITS'(1);
      if (line_wr)     data_cntr <= data_cntr + LINE_BITS'(1);
      if (FLUSH && (state != S_IDLE)) discard <= 1'b1;

      if (state == S_WAIT && !DRDY) begin
        tmo_cntr <= tmo_sat;
        if (&tmo_sat) fatal_q <= 1'b1;
      end else begin
        tmo_cntr <= '0;
      end

      if (fill_done && !discard) valid[page_idx] <= 1'b1;

      // the slot being refilled must not hit on stale data under its new tag
      if (start_fill) begin
        page           <= f_page;
        pf_fill        <= 1'b0;
        discard        <= 1'b0;
        load_cntr      <= '0;
        data_cntr      <= '0;
        valid[f_idx]   <= 1'b0;
      end
      if (start_pf) begin
        page           <= pf_page;
        pf_fill        <= 1'b1;
        discard        <= 1'b0;
        load_cntr      <= '0;
        data_cntr      <= '0;
        valid[pf_idx]  <= 1'b0;
      end

      // flush wins over a completion in the same cycle
      if (FLUSH) valid <= '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (start_fill)    tag_ram[f_idx]  <= f_tag;
    else if (start_pf) tag_ram[pf_idx] <= pf_tag;
  end

  // discarded fills are still written so bus order is kept; the slot stays invalid
  always_ff @(posedge CLK) begin
    if (line_wr) data_ram[{page_idx, data_cntr}] <= {DERR, DTi};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      fdata_q <= '0;
      ferr_q  <= 1'b0;
    end else if (FREQ && hit) begin
      {ferr_q, fdata_q} <= data_ram[{f_idx, f_line}];
    end
  end

  assign FRDY   = frdy_q;
  assign FDATA  = fdata_q;
  assign FERR   = ferr_q;
  assign ACT    = act;
  assign OFFSET = act ? {page, load_cntr, 3'b000} : '0;
  assign TAGo   = act ? {last_load, pf_fill, 1'b0} : 3'b000;
  assign BUSY   = (state != S_IDLE);
  assign FATAL  = fatal_q;

endmodule
